// File: rtl/vdac_sequencer.sv
// -----------------------------------------------------------------------------
// vdac_sequencer
//   Sample-rate sequencer for the signed voltage DAC. Samples arrive from an
//   upstream valid/ready source and are buffered in a small FIFO. Once the FIFO
//   has primed, one sample is presented on the DAC data input every div+1
//   clocks. The block also handles underflow and an orderly drain/power-down.
//
// Handshake: a sample is transferred on every rising clk edge where
//   in_valid_i & in_ready_o. in_ready_o depends only on registered FIFO
//   occupancy (no combinational path from the pop side); the source may hold
//   in_valid_i/in_data_i until it sees the transfer.
//
// Ports
//   clk_i           in   system clock
//   reset_n_i       in   synchronous reset, active low
//   start_i         in   request playback (pulse)
//   stop_i          in   request drain and stop (pulse), wins over start_i
//   div_i           in   sample period = div_i+1 clocks, latched on start
//   in_data_i       in   sample from source (two's complement)
//   in_valid_i      in   in_data_i valid
//   in_ready_o      out  FIFO not full
//   dac_data_o      out  registered DAC code
//   dac_enable_o    out  registered DAC enable (high outside IDLE)
//   running_o       out  sequencer not idle
//   underflow_o     out  sticky underflow flag
//   underflow_clr_i in   clears underflow_o (a new underflow has priority)
//   fifo_level_o    out  current FIFO occupancy
//   state_o         out  FSM state, debug visibility
// -----------------------------------------------------------------------------
module vdac_sequencer #(
   parameter int BITWIDTH    = 6,
   parameter int FIFO_DEPTH  = 8,
   parameter int PRIME_LEVEL = 4,
   parameter int DIV_WIDTH   = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        start_i,
   input  logic                        stop_i,
   input  logic [DIV_WIDTH-1:0]        div_i,
   input  logic [BITWIDTH-1:0]         in_data_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   output logic [BITWIDTH-1:0]         dac_data_o,
   output logic                        dac_enable_o,
   output logic                        running_o,
   output logic                        underflow_o,
   input  logic                        underflow_clr_i,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
   output logic [1:0]                  state_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [BITWIDTH-1:0]   data_q, data_d;
   logic                  enable_q, enable_d;
   logic                  underflow_q, underflow_d;
   logic [LW-1:0]         level_q, level_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [BITWIDTH-1:0]   mem_q [FIFO_DEPTH];

   logic full, empty, push, pop, active, slot;
   logic [BITWIDTH-1:0] head;

   // FIFO bookkeeping. A pop is only ever requested at a pop slot with data
   // present, so an empty FIFO never sees a pop.
   always_comb begin
      full   = (level_q == DEPTH_L);
      empty  = (level_q == '0);
      push   = in_valid_i & ~full;
      active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      slot   = active && (cnt_q == '0);
      pop    = slot && !empty;
      head   = mem_q[rd_ptr_q];

      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
   end

   // Sequencer next-state and registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      data_d      = data_q;
      underflow_d = underflow_q;

      if (underflow_clr_i) underflow_d = 1'b0;

      // Period counter free-runs 0..div_q while playing.
      if (active) cnt_d = (cnt_q == div_q) ? '0 : cnt_q + DIV_WIDTH'(1);

      case (state_q)
         ST_IDLE: begin
            if (start_i && !stop_i) begin
               state_d = ST_PRIME;
               div_d   = div_i;
               cnt_d   = '0;
            end
         end
         ST_PRIME: begin
            if (stop_i) begin
               state_d = ST_IDLE;
            end else if (level_q >= PRIME_L) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (slot) begin
               if (empty) begin
                  data_d      = '0;
                  underflow_d = 1'b1;   // set beats a same-cycle clear
               end else begin
                  data_d = head;
               end
            end
            if (stop_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (slot) begin
               if (empty) begin
                  state_d = ST_IDLE;
                  data_d  = '0;
                  cnt_d   = '0;
               end else begin
                  data_d = head;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Enable follows the next state so it drops on the same edge as the
      // data returns to zero when leaving to IDLE.
      enable_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         div_q       <= '0;
         data_q      <= '0;
         enable_q    <= 1'b0;
         underflow_q <= 1'b0;
         level_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         data_q      <= data_d;
         enable_q    <= enable_d;
         underflow_q <= underflow_d;
         level_q     <= level_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Storage needs no reset: occupancy and pointers define valid entries.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

   assign in_ready_o   = ~full;
   assign dac_data_o   = data_q;
   assign dac_enable_o = enable_q;
   assign running_o    = (state_q != ST_IDLE);
   assign underflow_o  = underflow_q;
   assign fifo_level_o = level_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_vdac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vdac_sequencer
//   Self-checking bench for vdac_sequencer: a table of single-cycle control
//   vectors, then hand-written multi-cycle sequences. Pushed samples go to an
//   expected queue and are popped when the DAC should present them.
// -----------------------------------------------------------------------------
module tb_vdac_sequencer;

   localparam int BW = 6;
   localparam int FD = 8;
   localparam int PL = 4;
   localparam int DW = 16;
   localparam int LW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n  = 1'b0;
   logic          start    = 1'b0;
   logic          stop     = 1'b0;
   logic [DW-1:0] div      = '0;
   logic [BW-1:0] in_data  = '0;
   logic          in_valid = 1'b0;
   logic          uf_clr   = 1'b0;

   logic          in_ready;
   logic [BW-1:0] dac_data;
   logic          dac_enable;
   logic          running;
   logic          underflow;
   logic [LW-1:0] level;
   logic [1:0]    dbg_state;

   vdac_sequencer #(
      .BITWIDTH(BW), .FIFO_DEPTH(FD), .PRIME_LEVEL(PL), .DIV_WIDTH(DW)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .stop_i(stop),
      .div_i(div), .in_data_i(in_data), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .dac_data_o(dac_data), .dac_enable_o(dac_enable),
      .running_o(running), .underflow_o(underflow), .underflow_clr_i(uf_clr),
      .fifo_level_o(level), .state_o(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [BW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_next(input string name, output logic [BW-1:0] e);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         e = '0;
         $display("FAIL %s: expected queue empty, dac_data %0h", name, dac_data);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(dac_data), 32'(e));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; uf_clr = 1'b0;
      tick();
      reset_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_data"},      32'(dac_data), 32'd0);
      check({tag, "_enable"},    32'(dac_enable), 32'd0);
      check({tag, "_running"},   32'(running), 32'd0);
      check({tag, "_underflow"}, 32'(underflow), 32'd0);
      check({tag, "_level"},     32'(level), 32'd0);
      check({tag, "_ready"},     32'(in_ready), 32'd1);
   endtask

   task automatic push(input logic [BW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      exp_q.push_back(d);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic start_pulse(input logic [DW-1:0] d);
      div   = d;
      start = 1'b1;
      tick();
      start = 1'b0;
      div   = 16'hffff;   // later changes must not affect the period
   endtask

   // Each sample appears on a slot edge and must hold for d further cycles.
   task automatic play(input int n, input int d);
      logic [BW-1:0] e;
      for (int k = 0; k < n; k++) begin
         tick();
         check_next("sample", e);
         check("sample_enable", 32'(dac_enable), 32'd1);
         for (int h = 0; h < d; h++) begin
            tick();
            check("sample_hold", 32'(dac_data), 32'(e));
         end
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         tick();
         if (!running) break;
      end
      check({name, "_idle_reached"}, 32'(running), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          start;
      logic          stop;
      logic          valid;
      logic [BW-1:0] data;
      logic          exp_running;
      logic          exp_enable;
      logic          exp_ready;
      logic [LW-1:0] exp_level;
      logic [BW-1:0] exp_data;
   } vec_t;

   vec_t vecs[11];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [BW-1:0] e;

      //                start stop valid data   run en  rdy lvl  data
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 4'd1, 6'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 6'd7,  1'b0, 1'b0, 1'b1, 4'd2, 6'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 4'd2, 6'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 4'd2, 6'd0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 4'd2, 6'd0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 4'd2, 6'd0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 4'd2, 6'd0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 6'd9,  1'b0, 1'b0, 1'b1, 4'd3, 6'd0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 6'd11, 1'b1, 1'b1, 1'b1, 4'd4, 6'd0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 4'd4, 6'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 4'd3, 6'd5};

      // Reset and control vectors
      do_reset();
      check_reset_values("reset");
      div = 16'd100;
      for (int i = 0; i < 11; i++) begin
         start    = vecs[i].start;
         stop     = vecs[i].stop;
         in_valid = vecs[i].valid;
         in_data  = vecs[i].data;
         tick();
         start = 1'b0; stop = 1'b0; in_valid = 1'b0;
         check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_running));
         check($sformatf("vec%0d_enable", i),  32'(dac_enable), 32'(vecs[i].exp_enable));
         check($sformatf("vec%0d_ready", i),   32'(in_ready), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d_level", i),   32'(level), 32'(vecs[i].exp_level));
         check($sformatf("vec%0d_data", i),    32'(dac_data), 32'(vecs[i].exp_data));
      end

      // Prime with 4 samples, period 4, then underflow and drain to idle
      do_reset();
      check_reset_values("t1_reset");
      push(6'd1); push(6'd2); push(6'd3); push(6'b111100);
      check("t1_level", 32'(level), 32'd4);
      start_pulse(16'd3);
      check("t1_prime_running", 32'(running), 32'd1);
      check("t1_prime_enable", 32'(dac_enable), 32'd1);
      check("t1_prime_data", 32'(dac_data), 32'd0);
      tick();
      check("t1_run_entry_data", 32'(dac_data), 32'd0);
      play(4, 3);
      tick();
      check("t1_underflow", 32'(underflow), 32'd1);
      check("t1_uf_data", 32'(dac_data), 32'd0);
      check("t1_uf_enable", 32'(dac_enable), 32'd1);
      check("t1_uf_running", 32'(running), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("t1", 10);
      check("t1_idle_enable", 32'(dac_enable), 32'd0);
      check("t1_idle_data", 32'(dac_data), 32'd0);
      check("t1_uf_sticky", 32'(underflow), 32'd1);
      uf_clr = 1'b1;
      tick();
      uf_clr = 1'b0;
      check("t1_uf_cleared", 32'(underflow), 32'd0);

      // Full FIFO, period 1: eight back-to-back codes then underflow
      for (int i = 0; i < FD; i++) push(BW'($urandom_range(0, 63)));
      check("t2_level_full", 32'(level), 32'd8);
      check("t2_ready_full", 32'(in_ready), 32'd0);
      start_pulse(16'd0);
      tick();
      play(8, 0);
      tick();
      check("t2_underflow", 32'(underflow), 32'd1);
      check("t2_uf_data", 32'(dac_data), 32'd0);
      check("t2_uf_enable", 32'(dac_enable), 32'd1);
      uf_clr = 1'b1;
      tick();
      uf_clr = 1'b0;
      check("t2_set_beats_clr", 32'(underflow), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("t2", 4);
      check("t2_idle_enable", 32'(dac_enable), 32'd0);
      uf_clr = 1'b1;
      tick();
      uf_clr = 1'b0;
      check("t2_uf_cleared", 32'(underflow), 32'd0);

      // Push held against a full FIFO while a pop frees a slot
      do_reset();
      for (int i = 0; i < FD; i++) push(BW'($urandom_range(0, 63)));
      check("t3_ready_full", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_data  = 6'd42;
      start_pulse(16'd9);
      check("t3_prime_level", 32'(level), 32'd8);
      tick();
      check("t3_run_level", 32'(level), 32'd8);
      tick();
      check_next("t3_first_sample", e);
      check("t3_level_after_pop", 32'(level), 32'd7);
      check("t3_ready_after_pop", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("t3_level_refill", 32'(level), 32'd8);
      check("t3_ready_refill", 32'(in_ready), 32'd0);

      // Reset in the middle of playback
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      exp_q.delete();
      check_reset_values("t6_midrun_reset");

      // Stop with three samples still queued: all play, then idle
      push(6'd10); push(6'd20); push(6'd30); push(6'd40);
      start_pulse(16'd1);
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_next("t4_first_sample", e);
      check("t4_drain_running", 32'(running), 32'd1);
      tick();
      check("t4_first_hold", 32'(dac_data), 32'(e));
      play(3, 1);
      tick();
      check("t4_idle_running", 32'(running), 32'd0);
      check("t4_idle_enable", 32'(dac_enable), 32'd0);
      check("t4_idle_data", 32'(dac_data), 32'd0);
      check("t4_idle_level", 32'(level), 32'd0);
      check("t4_no_underflow", 32'(underflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
